// File: rtl/mc_control_sequencer.sv
// rtl/mc_control_sequencer.sv - multi-cycle CPU control sequencer: state register, strobe decode, HALT latch, retire counter
module mc_control_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [5:0]       Opcode,
  input  logic             zero,
  input  logic             sign,
  input  logic             mem_ready,
  output logic [2:0]       state,
  output logic             PCWre,
  output logic             IRWre,
  output logic             InsMemRW,
  output logic             RegWre,
  output logic             mRD,
  output logic             mWR,
  output logic             ALUSrcA,
  output logic             ALUSrcB,
  output logic             ExtSel,
  output logic [1:0]       RegDst,
  output logic             WrRegDSrc,
  output logic             DBDataSrc,
  output logic [1:0]       PCSrc,
  output logic [2:0]       ALUOp,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_WB   = 3'b011,
    S_MEM  = 3'b100,
    S_HALT = 3'b111
  } state_t;

  localparam logic [5:0] OP_ADD  = 6'b000000, OP_SUB  = 6'b000001, OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000, OP_AND  = 6'b010001, OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLL  = 6'b011000, OP_SLT  = 6'b100110, OP_SLTI = 6'b100111;
  localparam logic [5:0] OP_SW   = 6'b110000, OP_LW   = 6'b110001, OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_BNE  = 6'b110101, OP_BGTZ = 6'b110110, OP_J    = 6'b111000;
  localparam logic [5:0] OP_JR   = 6'b111001, OP_JAL  = 6'b111010, OP_HALT = 6'b111111;

  state_t state_q;
  logic   is_jump, is_branch, is_mem, is_rtype, taken;

  assign state     = state_q;
  assign is_jump   = (Opcode == OP_J) || (Opcode == OP_JR) || (Opcode == OP_JAL);
  assign is_branch = (Opcode == OP_BEQ) || (Opcode == OP_BNE) || (Opcode == OP_BGTZ);
  assign is_mem    = (Opcode == OP_LW) || (Opcode == OP_SW);
  assign is_rtype  = (Opcode == OP_ADD) || (Opcode == OP_SUB) || (Opcode == OP_OR) ||
                     (Opcode == OP_AND) || (Opcode == OP_SLL) || (Opcode == OP_SLT);

  always_comb begin
    taken = 1'b0;
    case (Opcode)
      OP_BEQ:  taken = zero;
      OP_BNE:  taken = !zero;
      OP_BGTZ: taken = !zero && !sign;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IF;
      halted      <= 1'b0;
      instr_count <= '0;
    end else begin
      // Every PC write retires exactly one instruction.
      if (PCWre) instr_count <= instr_count + CNT_W'(1);
      case (state_q)
        S_IF: state_q <= S_ID;
        S_ID: begin
          if (is_jump) state_q <= S_IF;
          else if (Opcode == OP_HALT) begin
            state_q <= S_HALT;
            halted  <= 1'b1;
          end else state_q <= S_EXE;
        end
        S_EXE: begin
          if (is_branch)   state_q <= S_IF;
          else if (is_mem) state_q <= S_MEM;
          else             state_q <= S_WB;
        end
        S_MEM:   if (mem_ready) state_q <= (Opcode == OP_LW) ? S_WB : S_IF;
        S_WB:    state_q <= S_IF;
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_IF;
      endcase
    end
  end

  always_comb begin
    PCWre = 1'b0; IRWre = 1'b0; InsMemRW = 1'b0; RegWre = 1'b0;
    mRD = 1'b0; mWR = 1'b0; ALUSrcA = 1'b0; ALUSrcB = 1'b0; ExtSel = 1'b0;
    RegDst = 2'b00; WrRegDSrc = 1'b0; DBDataSrc = 1'b0; PCSrc = 2'b00; ALUOp = 3'b000;

    // ALU controls stay stable from EXE through WB so the result is held.
    if (state_q == S_EXE || state_q == S_MEM || state_q == S_WB) begin
      ALUSrcA = (Opcode == OP_SLL);
      ALUSrcB = (Opcode == OP_ADDI) || (Opcode == OP_ORI) || (Opcode == OP_SLTI) || is_mem;
      ExtSel  = (Opcode != OP_ORI);
      case (Opcode)
        OP_SUB, OP_BEQ, OP_BNE, OP_BGTZ: ALUOp = 3'b001;
        OP_SLL:                          ALUOp = 3'b010;
        OP_OR, OP_ORI:                   ALUOp = 3'b011;
        OP_AND:                          ALUOp = 3'b100;
        OP_SLT, OP_SLTI:                 ALUOp = 3'b101;
        default:                         ALUOp = 3'b000;
      endcase
    end

    case (state_q)
      S_IF: begin
        InsMemRW = 1'b1;
        IRWre    = 1'b1;
      end
      S_ID: begin
        case (Opcode)
          OP_J:  begin PCWre = 1'b1; PCSrc = 2'b11; end
          OP_JR: begin PCWre = 1'b1; PCSrc = 2'b10; end
          OP_JAL: begin
            PCWre  = 1'b1;
            PCSrc  = 2'b11;
            RegWre = 1'b1;
          end
          default: ;
        endcase
      end
      S_EXE: begin
        if (is_branch) begin
          PCWre = 1'b1;
          PCSrc = taken ? 2'b01 : 2'b00;
        end
      end
      S_MEM: begin
        mRD = (Opcode == OP_LW);
        mWR = (Opcode == OP_SW);
        if (Opcode == OP_SW && mem_ready) PCWre = 1'b1;
      end
      S_WB: begin
        RegWre    = 1'b1;
        PCWre     = 1'b1;
        WrRegDSrc = 1'b1;
        DBDataSrc = (Opcode == OP_LW);
        RegDst    = is_rtype ? 2'b10 : 2'b01;
      end
      default: ;
    endcase
  end

endmodule
